// File: rtl/aes_key_sched_ctrl_if.sv
// Key handshake, schedule view and round-key read port of the AES-128 key-schedule sequencer.
interface aes_key_sched_ctrl_if #(
  parameter int KEY_W   = 128,
  parameter int SCHED_W = 1408
);
  logic               i_key_valid;
  logic               o_key_ready;
  logic [0:KEY_W-1]   i_key;
  logic               i_abort;
  logic               o_busy;
  logic               o_sched_valid;
  logic [0:SCHED_W-1] o_key_schedule;
  logic [3:0]         o_rounds_done;
  logic [3:0]         i_rd_round;
  logic [0:KEY_W-1]   o_rd_key;
  logic               o_rd_valid;

  modport master (
    output i_key_valid, i_key, i_abort, i_rd_round,
    input  o_key_ready, o_busy, o_sched_valid, o_key_schedule,
           o_rounds_done, o_rd_key, o_rd_valid
  );

  modport slave (
    input  i_key_valid, i_key, i_abort, i_rd_round,
    output o_key_ready, o_busy, o_sched_valid, o_key_schedule,
           o_rounds_done, o_rd_key, o_rd_valid
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion: one round key per cycle through a shared
// RotWord/SubWord/Rcon function, with progress count and registered read port.
module aes_key_sched_ctrl #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int SCHED_W    = KEY_W * (NUM_ROUNDS + 1)
) (
  input logic           clk,
  input logic           rst,
  aes_key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0]       LAST_RND = 4'(NUM_ROUNDS);
  localparam logic [0:KEY_W-1] ZERO_KEY = {KEY_W{1'b0}};

  // Forward S-box, byte n at bits [8n : 8n+7]
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {b, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [0:KEY_W-1] next_rk(input logic [0:KEY_W-1] prev,
                                               input logic [7:0]       rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = prev[0:31];
    w1 = prev[32:63];
    w2 = prev[64:95];
    w3 = prev[96:127];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t             state_r, state_nx;
  logic [0:KEY_W-1]   rk_r [0:NUM_ROUNDS];
  logic [3:0]         round_r;
  logic [3:0]         rounds_done_r;
  logic               busy_r;
  logic               sched_valid_r;
  logic [0:KEY_W-1]   rd_key_r;
  logic               rd_valid_r;
  logic               key_ready_s;
  logic               accept_s;
  logic               expand_s;
  logic               clear_s;
  logic [0:SCHED_W-1] sched_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and handshake decode; abort outranks a simultaneous key
  always_comb begin
    state_nx    = state_r;
    key_ready_s = 1'b0;
    accept_s    = 1'b0;
    expand_s    = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE:   key_ready_s = ~bus.i_abort;
      ST_EXPAND: key_ready_s = 1'b0;
      ST_DONE:   key_ready_s = ~bus.i_abort;
      default:   key_ready_s = 1'b0;
    endcase
    if (bus.i_abort) begin
      clear_s  = 1'b1;
      state_nx = ST_IDLE;
    end else if (key_ready_s && bus.i_key_valid) begin
      accept_s = 1'b1;
      state_nx = ST_EXPAND;
    end else if (state_r == ST_EXPAND) begin
      expand_s = 1'b1;
      if (round_r == LAST_RND) begin
        state_nx = ST_DONE;
      end else begin
        state_nx = ST_EXPAND;
      end
    end else if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      state_nx = state_r;
    end else begin
      state_nx = ST_IDLE;
    end
  end

  // Round-key registers, round counter, progress and status flags
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      for (int k = 0; k <= NUM_ROUNDS; k++) begin
        rk_r[k] <= ZERO_KEY;
      end
      round_r       <= 4'd0;
      rounds_done_r <= 4'd0;
      busy_r        <= 1'b0;
      sched_valid_r <= 1'b0;
    end else if (accept_s) begin
      rk_r[0] <= bus.i_key;
      for (int k = 1; k <= NUM_ROUNDS; k++) begin
        rk_r[k] <= ZERO_KEY;
      end
      round_r       <= 4'd1;
      rounds_done_r <= 4'd0;
      busy_r        <= 1'b1;
      sched_valid_r <= 1'b0;
    end else if (expand_s) begin
      rk_r[round_r] <= next_rk(rk_r[round_r - 4'd1], rcon_of(round_r));
      rounds_done_r <= round_r;
      round_r       <= round_r + 4'd1;
      if (round_r == LAST_RND) begin
        busy_r        <= 1'b0;
        sched_valid_r <= 1'b1;
      end
    end
  end

  // Registered read port; a key written this same edge is not yet reported valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_r   <= ZERO_KEY;
      rd_valid_r <= 1'b0;
    end else if (bus.i_rd_round <= LAST_RND) begin
      rd_key_r   <= rk_r[bus.i_rd_round];
      rd_valid_r <= (state_r != ST_IDLE) && (bus.i_rd_round <= rounds_done_r);
    end else begin
      rd_key_r   <= ZERO_KEY;
      rd_valid_r <= 1'b0;
    end
  end

  // Flat schedule view, round key k at bits [KEY_W*k +: KEY_W]
  always_comb begin
    sched_s = {SCHED_W{1'b0}};
    for (int k = 0; k <= NUM_ROUNDS; k++) begin
      sched_s[k*KEY_W +: KEY_W] = rk_r[k];
    end
  end

  assign bus.o_key_ready    = key_ready_s;
  assign bus.o_busy         = busy_r;
  assign bus.o_sched_valid  = sched_valid_r;
  assign bus.o_rounds_done  = rounds_done_r;
  assign bus.o_key_schedule = sched_s;
  assign bus.o_rd_key       = rd_key_r;
  assign bus.o_rd_valid     = rd_valid_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] a1_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rk_of(input int k);
    return bus.o_key_schedule[k*128 +: 128];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   128'(bus.o_busy), 128'd0);
    chk({tag, "_sv"},     128'(bus.o_sched_valid), 128'd0);
    chk({tag, "_rdone"},  128'(bus.o_rounds_done), 128'd0);
    chk({tag, "_rdv"},    128'(bus.o_rd_valid), 128'd0);
    chk({tag, "_rdkey"},  bus.o_rd_key, 128'd0);
    chk({tag, "_schedz"}, 128'(|bus.o_key_schedule), 128'd0);
  endtask

  initial begin
    logic [127:0] exp_k;
    logic         exp_v;

    rst             = 1'b1;
    bus.i_key_valid = 1'b0;
    bus.i_key       = 128'd0;
    bus.i_abort     = 1'b0;
    bus.i_rd_round  = 4'd0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("ready_idle", 128'(bus.o_key_ready), 128'd1);

    // FIPS-197 A.1 expansion with progress-tracking reads
    bus.i_key       = K1;
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a1_rdone_%0d", i), 128'(bus.o_rounds_done), 128'(i));
      chk($sformatf("a1_sv_%0d", i), 128'(bus.o_sched_valid), 128'd0);
      chk($sformatf("a1_busy_%0d", i), 128'(bus.o_busy), 128'd1);
      chk($sformatf("a1_rk%0d", i), rk_of(i), a1_rk[i]);
      chk($sformatf("a1_above_%0d", i), rk_of(i + 1), 128'd0);
      case (i % 3)
        0: begin bus.i_rd_round = 4'(i);     exp_v = 1'b1; exp_k = a1_rk[i]; end
        1: begin bus.i_rd_round = 4'(i + 1); exp_v = 1'b0; exp_k = 128'd0;   end
        default: begin bus.i_rd_round = 4'd12; exp_v = 1'b0; exp_k = 128'd0; end
      endcase
      tick();
      chk($sformatf("a1_rdv_%0d", i), 128'(bus.o_rd_valid), 128'(exp_v));
      chk($sformatf("a1_rdkey_%0d", i), bus.o_rd_key, exp_k);
    end
    chk("a1_rdone_10", 128'(bus.o_rounds_done), 128'd10);
    chk("a1_sv_done", 128'(bus.o_sched_valid), 128'd1);
    chk("a1_busy_done", 128'(bus.o_busy), 128'd0);
    chk("a1_rk1", rk_of(1), a1_rk[1]);
    chk("a1_rk10", rk_of(10), a1_rk[10]);

    // Back-to-back key in the first DONE cycle, then a held key during EXPAND
    bus.i_rd_round  = 4'd10;
    bus.i_key       = K2;
    bus.i_key_valid = 1'b1;
    #1;
    chk("b2b_ready", 128'(bus.o_key_ready), 128'd1);
    tick();
    chk("done_rdv", 128'(bus.o_rd_valid), 128'd1);
    chk("done_rdkey", bus.o_rd_key, a1_rk[10]);
    chk("b2b_sv0", 128'(bus.o_sched_valid), 128'd0);
    chk("b2b_rdone0", 128'(bus.o_rounds_done), 128'd0);
    chk("b2b_rk0", rk_of(0), K2);
    bus.i_key = K1;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("hold_ready_%0d", c), 128'(bus.o_key_ready), 128'd0);
      tick();
      if (c < 10) begin
        chk($sformatf("b2b_sv_%0d", c), 128'(bus.o_sched_valid), 128'd0);
        chk($sformatf("hold_rk0_%0d", c), rk_of(0), K2);
      end
    end
    chk("b2b_sv_done", 128'(bus.o_sched_valid), 128'd1);
    chk("b2b_rk1", rk_of(1), K2_RK1);
    chk("b2b_rk10", rk_of(10), K2_RK10);
    #1;
    chk("hold_ready_done", 128'(bus.o_key_ready), 128'd1);
    tick();
    bus.i_key_valid = 1'b0;
    chk("hold_acc_rk0", rk_of(0), K1);
    chk("hold_acc_rdone", 128'(bus.o_rounds_done), 128'd0);
    chk("hold_acc_sv", 128'(bus.o_sched_valid), 128'd0);

    // Abort at round 5 together with a new key
    repeat (5) tick();
    chk("abort_pre_rdone", 128'(bus.o_rounds_done), 128'd5);
    bus.i_abort     = 1'b1;
    bus.i_key_valid = 1'b1;
    bus.i_key       = K2;
    #1;
    chk("abort_ready", 128'(bus.o_key_ready), 128'd0);
    tick();
    bus.i_abort     = 1'b0;
    bus.i_key_valid = 1'b0;
    chk("abort_rdone", 128'(bus.o_rounds_done), 128'd0);
    chk("abort_busy", 128'(bus.o_busy), 128'd0);
    chk("abort_sv", 128'(bus.o_sched_valid), 128'd0);
    chk("abort_schedz", 128'(|bus.o_key_schedule), 128'd0);
    #1;
    chk("abort_ready_idle", 128'(bus.o_key_ready), 128'd1);
    bus.i_key       = K1;
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid = 1'b0;
    repeat (10) tick();
    chk("post_abort_sv", 128'(bus.o_sched_valid), 128'd1);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("post_abort_rk%0d", k), rk_of(k), a1_rk[k]);
    end

    // Reset in the middle of an expansion
    bus.i_key       = K2;
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid = 1'b0;
    repeat (3) tick();
    chk("rst_pre_rdone", 128'(bus.o_rounds_done), 128'd3);
    bus.i_rd_round = 4'd0;
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    #1;
    chk("midrst_ready", 128'(bus.o_key_ready), 128'd1);
    tick();
    chk("midrst_idle_busy", 128'(bus.o_busy), 128'd0);
    chk("midrst_idle_rdv", 128'(bus.o_rd_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
